// File: rtl/source_mem_mc.sv
// Multi-channel PCM pattern source: per-channel waveform banks played as frames
// of signal_len stored samples plus sep zero samples, on a valid/ready stream.
module source_mem_mc #(
  parameter int DW  = 16,
  parameter int AW  = 10,
  parameter int CHW = 1,
  parameter int SW  = 12,
  parameter int NW  = 8
) (
  input  logic                      pcm_clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [CHW-1:0]            wr_ch,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      continuous,
  input  logic [NW-1:0]             burst_num,
  input  logic [SW-1:0]             sep,
  input  logic [AW-1:0]             signal_len,
  input  logic [(2**CHW)-1:0]       ch_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      pcm_out_valid,
  input  logic                      pcm_out_ready,
  output logic [(2**CHW)*DW-1:0]    pcm_out
);
  localparam int CH = 2**CHW;

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DRAIN} state_t;
  state_t state;

  logic [AW-1:0]    addr, len_q;
  logic [SW-1:0]    gap_cnt, sep_q;
  logic [NW-1:0]    frame_cnt, burst_q;
  logic             cont_q, stop_pending;
  logic [CH-1:0]    mask_q;
  logic             stage_valid, stage_zero;
  logic [CH*DW-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [CH*DW-1:0] push_data;

  logic            idle, pop, has_space, start_ok, issue_read, issue_gap;
  logic            last_read, last_gap, frame_end, to_drain, drain_ok, act_cont;
  logic [AW-1:0]   act_len;
  logic [SW-1:0]   act_sep;
  logic [NW-1:0]   act_burst, burst_eff, frame_inc;
  logic [2:0]      occ;

  // In IDLE the start cycle already issues the first read, so it works from the live inputs.
  always_comb begin
    idle       = (state == IDLE);
    act_len    = idle ? signal_len : len_q;
    act_sep    = idle ? sep        : sep_q;
    act_burst  = idle ? burst_num  : burst_q;
    act_cont   = idle ? continuous : cont_q;
    pop        = (count != 2'd0) && pcm_out_ready;
    occ        = {1'b0, count} + {2'b00, stage_valid};
    has_space  = occ < (pop ? 3'd3 : 3'd2);
    start_ok   = idle && start && (signal_len != '0);
    issue_read = start_ok || ((state == PLAY) && has_space);
    issue_gap  = (state == GAP) && has_space;
    last_read  = issue_read && (addr == act_len - AW'(1));
    last_gap   = issue_gap && (gap_cnt == sep_q - SW'(1));
    frame_end  = (last_read && (act_sep == '0)) || last_gap;
    frame_inc  = (frame_cnt == '1) ? frame_cnt : frame_cnt + NW'(1);
    burst_eff  = (act_burst == '0) ? NW'(1) : act_burst;
    to_drain   = stop_pending || (stop && !idle) || (!act_cont && (frame_inc == burst_eff));
    drain_ok   = !stage_valid && ((count == 2'd0) || ((count == 2'd1) && pop));
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_bank
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;
    always_ff @(posedge pcm_clk) begin
      if (wr_en && (wr_ch == CHW'(gi)))
        mem[wr_addr] <= wr_data;
      if (issue_read)
        q <= mem[addr];
    end
    assign push_data[gi*DW +: DW] = (stage_zero || !mask_q[gi]) ? '0 : q;
  end

  // One-slot read stage feeding a 2-entry FIFO; has_space keeps reads in flight within capacity.
  always_ff @(posedge pcm_clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_zero  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      stage_valid <= issue_read || issue_gap;
      stage_zero  <= issue_gap;
      if (stage_valid) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, stage_valid} - {1'b0, pop};
    end
  end

  assign pcm_out_valid = (count != 2'd0);
  assign pcm_out       = pcm_out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge pcm_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      gap_cnt      <= '0;
      frame_cnt    <= '0;
      len_q        <= '0;
      sep_q        <= '0;
      burst_q      <= '0;
      cont_q       <= 1'b0;
      mask_q       <= '0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && !idle)
        stop_pending <= 1'b1;
      case (state)
        IDLE: if (start) begin
          if (signal_len == '0) begin
            done <= 1'b1;
          end else begin
            len_q     <= signal_len;
            sep_q     <= sep;
            burst_q   <= burst_num;
            cont_q    <= continuous;
            mask_q    <= ch_mask;
            busy      <= 1'b1;
            frame_cnt <= '0;
            state     <= PLAY;
          end
        end
        DRAIN: if (drain_ok) begin
          done         <= 1'b1;
          busy         <= 1'b0;
          stop_pending <= 1'b0;
          frame_cnt    <= '0;
          state        <= IDLE;
        end
        default: ;
      endcase
      if (issue_read) begin
        if (last_read) begin
          addr <= '0;
          if (act_sep != '0)
            state <= GAP;
        end else begin
          addr <= addr + AW'(1);
        end
      end
      if (issue_gap)
        gap_cnt <= last_gap ? '0 : gap_cnt + SW'(1);
      // Frame boundary overrides the PLAY/GAP transitions above.
      if (frame_end) begin
        frame_cnt <= frame_inc;
        state     <= to_drain ? DRAIN : PLAY;
      end
    end
  end
endmodule

// File: tb/tb_source_mem_mc.sv
// Directed bench for source_mem_mc: frame playback, stalls, stop, mask,
// write/read collision and mid-run reset, with hand-computed beat sequences.
module tb_source_mem_mc;
  logic        pcm_clk = 1'b0;
  logic        rst, wr_en, start, stop, continuous, pcm_out_ready;
  logic [0:0]  wr_ch;
  logic [9:0]  wr_addr, signal_len;
  logic [15:0] wr_data;
  logic [7:0]  burst_num;
  logic [11:0] sep;
  logic [1:0]  ch_mask;
  logic        busy, done, pcm_out_valid;
  logic [31:0] pcm_out;

  source_mem_mc dut (
    .pcm_clk(pcm_clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stop(stop), .continuous(continuous),
    .burst_num(burst_num), .sep(sep), .signal_len(signal_len), .ch_mask(ch_mask),
    .busy(busy), .done(done), .pcm_out_valid(pcm_out_valid),
    .pcm_out_ready(pcm_out_ready), .pcm_out(pcm_out)
  );

  always #5 pcm_clk = ~pcm_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];
  int          done_cyc;
  bit          busy_seen;

  logic [31:0] f4[6] = '{32'h000A0001, 32'h00140002, 32'h001E0003, 32'h00280004, 32'h0, 32'h0};
  logic [31:0] f3[3] = '{32'h000A0001, 32'h00140002, 32'h001E0003};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic wr(input logic ch, input logic [9:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_addr = a; wr_data = d;
    @(posedge pcm_clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic cfg(input int len, input int sp, input int bn, input logic cont, input logic [1:0] m);
    signal_len = 10'(len); sep = 12'(sp); burst_num = 8'(bn); continuous = cont; ch_mask = m;
  endtask

  // Pulses start, then one iteration per cycle: drive at posedge+1, sample at negedge.
  task automatic run(input bit rnd, input int stop_cyc, input int start2_cyc, input int wcyc, input int max_cyc);
    bit          prev_stall = 1'b0;
    logic [31:0] prev_out = '0;
    got.delete(); got_cyc.delete(); done_cyc = -1; busy_seen = 1'b0;
    start = 1'b1;
    pcm_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc > 0) begin
        @(posedge pcm_clk); #1;
        start = (cyc == start2_cyc);
        stop  = (cyc == stop_cyc);
        wr_en = (cyc == wcyc); wr_ch = 1'b0; wr_addr = 10'd1; wr_data = 16'd99;
        pcm_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge pcm_clk);
      if (cyc > 0 && busy) busy_seen = 1'b1;
      if (prev_stall) begin
        chk($sformatf("stall_valid_c%0d", cyc), 64'(pcm_out_valid), 64'd1);
        chk($sformatf("stall_data_c%0d", cyc), 64'(pcm_out), 64'(prev_out));
      end
      prev_stall = pcm_out_valid && !pcm_out_ready;
      prev_out   = pcm_out;
      if (pcm_out_valid && pcm_out_ready) begin
        got.push_back(pcm_out);
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    @(posedge pcm_clk); #1;
    start = 1'b0; stop = 1'b0; wr_en = 1'b0; pcm_out_ready = 1'b1;
    @(negedge pcm_clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    @(posedge pcm_clk); #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; pcm_out_ready = 1'b1;
    wr_ch = '0; wr_addr = '0; wr_data = '0;
    cfg(0, 0, 0, 1'b0, 2'b11);
    @(posedge pcm_clk); #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(pcm_out_valid), 64'd0);
    chk("rst_data", 64'(pcm_out), 64'd0);
    @(posedge pcm_clk); #1;
    rst = 1'b0;
    @(posedge pcm_clk); #1;

    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 10'(i), 16'(i + 1));
      wr(1'b1, 10'(i), 16'(10 * (i + 1)));
    end

    // Two frames of 4 samples + 2 zeros, ready held high.
    cfg(4, 2, 2, 1'b0, 2'b11);
    exp_q.delete();
    for (int f = 0; f < 2; f++) for (int i = 0; i < 6; i++) exp_q.push_back(f4[i]);
    run(1'b0, -1, -1, -1, 100);
    chk_beats("t1");
    chk("t1_first_valid", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'd2);
    chk("t1_done_lat", 64'(done_cyc), 64'(got_cyc.size() > 0 ? got_cyc[got_cyc.size()-1] + 1 : -1));

    // Same run with random back-pressure.
    run(1'b1, -1, -1, -1, 300);
    chk_beats("t2");

    // Continuous, stop during frame 5 (its reads occupy cycles 12..14), extra start ignored.
    cfg(3, 0, 0, 1'b1, 2'b11);
    exp_q.delete();
    for (int f = 0; f < 5; f++) for (int i = 0; i < 3; i++) exp_q.push_back(f3[i]);
    run(1'b0, 13, 6, -1, 200);
    chk_beats("t3");

    // Channel 1 masked off.
    cfg(2, 1, 1, 1'b0, 2'b01);
    exp_q = '{32'h00000001, 32'h00000002, 32'h00000000};
    run(1'b0, -1, -1, -1, 100);
    chk_beats("t4");

    // Zero-length start: immediate done, nothing emitted, never busy.
    cfg(0, 2, 1, 1'b0, 2'b11);
    exp_q.delete();
    run(1'b0, -1, -1, -1, 20);
    chk_beats("t5");
    chk("t5_done_cyc", 64'(done_cyc), 64'd1);
    chk("t5_busy", 64'(busy_seen), 64'd0);

    // Write addr1 of bank0 in the cycle it is read: old value first, new value next frame.
    cfg(4, 0, 2, 1'b0, 2'b11);
    exp_q = '{32'h000A0001, 32'h00140002, 32'h001E0003, 32'h00280004,
              32'h000A0001, 32'h00140063, 32'h001E0003, 32'h00280004};
    run(1'b0, -1, -1, 1, 100);
    chk_beats("t6");

    // Reset asserted while in the gap, then a clean restart.
    cfg(4, 2, 1, 1'b0, 2'b11);
    start = 1'b1;
    @(posedge pcm_clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge pcm_clk); #1; end
    chk("t7_pre_valid", 64'(pcm_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", 64'(pcm_out_valid), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_done", 64'(done), 64'd0);
    chk("t7_rst_data", 64'(pcm_out), 64'd0);
    repeat (2) begin
      @(negedge pcm_clk);
      chk("t7_no_done", 64'(done), 64'd0);
    end
    @(posedge pcm_clk); #1;
    rst = 1'b0;
    @(posedge pcm_clk); #1;
    exp_q = '{32'h000A0001, 32'h00140063, 32'h001E0003, 32'h00280004, 32'h0, 32'h0};
    run(1'b0, -1, -1, -1, 100);
    chk_beats("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/source_mem_mc.md
Name: source_mem_mc

Overview:
- Multi-channel, parametrised PCM pattern source for the ultrasound TX path; next generation of the single-channel source memory.
- Each channel owns a waveform RAM bank loaded over a write port.
- On start, emits frames of signal_len stored samples followed by sep zero samples, on a valid/ready stream.
- Runs for a programmed burst count or continuously, with graceful stop and per-channel mask.

Parameters:
DW, 16, sample width per channel
AW, 10, RAM address width; bank depth 2^AW
CHW, 1, log2 of channel count; CH = 2^CHW
SW, 12, width of sep
NW, 8, width of burst_num

Ports:
pcm_clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  RAM write strobe
wr_ch  in  CHW  bank select for write
wr_addr  in  AW  write address
wr_data  in  DW  write data
start  in  1  single-cycle start pulse
stop  in  1  single-cycle graceful stop request
continuous  in  1  1 = repeat frames until stop
burst_num  in  NW  frames per run when continuous=0
sep  in  SW  zero samples after each signal part
signal_len  in  AW  stored samples per frame, addresses 0..signal_len-1
ch_mask  in  CH  1 = channel enabled
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pcm_out_valid  out  1  output beat valid
pcm_out_ready  in  1  downstream ready
pcm_out  out  CH*DW  channel k in bits [k*DW +: DW]

Behaviour:
- Reset values: busy=0, done=0, pcm_out_valid=0, pcm_out=0, FSM=IDLE, all counters 0, output FIFO empty. RAM contents are not reset.
- Config capture: on an accepted start (FSM in IDLE), latch signal_len, sep, burst_num, continuous and ch_mask. Later input changes do not affect the run.
- Ignored starts:
  - start while busy is ignored.
  - start with signal_len=0: no beats are emitted; done pulses the next cycle; busy stays 0.
- FSM states: IDLE, PLAY, GAP, DRAIN.
- IDLE -> PLAY on accepted start; busy=1 from the next cycle.
- PLAY:
  - Issue RAM reads at addr 0..signal_len-1, one per cycle while the output FIFO has space.
  - After the last issued read: go to GAP if sep>0, otherwise end-of-frame.
- GAP: push sep all-zero beats into the FIFO, then end-of-frame.
- End-of-frame:
  - frame_cnt increments.
  - Go to DRAIN if any of: stop is pending; continuous=0 and frame_cnt == max(burst_num,1); the stop pulse arrives in the same cycle.
  - Otherwise go back to PLAY at addr 0.
  - burst_num=0 is treated as 1.
- Stop:
  - stop while busy sets stop_pending. The current frame, including its gap, always completes.
  - stop while IDLE is ignored.
- DRAIN: wait until the FIFO is empty and the last beat has been accepted. Then done=1 for one cycle, busy=0, go to IDLE.
- RAM:
  - Synchronous read, 1-cycle latency, read-first.
  - A write and a read to the same bank and address in the same cycle return the old data.
  - Writes are allowed at any time, including during a run.
- Output FIFO:
  - 2-entry skid FIFO; credit counts in-flight reads, so there is no overflow.
  - pcm_out_valid = FIFO not empty; a beat pops on valid&&ready.
  - With ready held high, throughput is 1 beat/cycle.
  - First beat is valid 2 cycles after the start cycle.
  - While valid=1 and ready=0, pcm_out and valid are held stable.
- Channel data: masked channels output 0 in every beat. Gap beats are 0 on all channels.
- Widths and wrap:
  - Address counter is AW bits; signal_len max 2^AW-1.
  - frame_cnt is NW bits and saturates in continuous mode; there is no wrap side-effect.
- Reset mid-run: everything returns immediately to reset values; no done pulse.

Test Plan:
- Load bank0 addr0..3 = 1,2,3,4 and bank1 = 10,20,30,40; signal_len=4, sep=2, burst_num=2, ready=1, mask=11 -> beats {1|10},{2|20},{3|30},{4|40},0,0 repeated twice; first valid at start+2; done 1 cycle after last handshake; 12 beats total.
- Same config with ready toggling 1,0,0,1 pseudo-randomly -> identical 12-beat sequence, no drop or duplicate, pcm_out stable while stalled.
- continuous=1, signal_len=3, sep=0; stop asserted mid-frame 5 -> frame 5 completes (15 beats total), then done; start pulsed during the run has no effect.
- mask=01, signal_len=2, sep=1 -> channel1 field always 0; channel0 field = 1,2,0.
- Write bank0 addr1 = 99 in the same cycle it is read -> old value 2 emitted; next frame emits 99.
- Assert rst mid-GAP -> valid, busy and done go to 0 immediately; no done pulse. After release, a new start plays from addr 0.
